// File: rtl/calc_pkg.sv
// Shared constants, types and helpers for the UDP calculator stage.
// CALC_CSUM_UPDATE_EN enables the incremental UDP checksum patch.
package calc_pkg;

  localparam int OFF_TPID   = 12;
  localparam int OFF_ETYPE  = 16;
  localparam int OFF_VERIHL = 18;
  localparam int OFF_PROTO  = 27;
  localparam int OFF_DPORT  = 40;
  localparam int OFF_CSUM   = 44;
  localparam int OFF_OPC    = 46;
  localparam int OFF_A      = 48;
  localparam int OFF_B      = 52;
  localparam int OFF_RES    = 56;

  localparam logic [15:0] TPID_VLAN   = 16'h8100;
  localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IPV4_VERIHL = 8'h45;
  localparam logic [7:0]  PROTO_UDP   = 8'h11;

  // Beat 0 must carry bytes 0..59, so at most 4 empty bytes.
  localparam logic [5:0]  MTY_MAX_SOP = 6'd4;

  typedef enum logic [15:0] {
    OPC_ADD_DEF = 16'h000D,
    OPC_SUB_DEF = 16'h001A
  } opc_e;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  function automatic logic [7:0] byte_at(
    input logic [511:0] d,
    input int           off
  );
    return d[8*off +: 8];
  endfunction

  function automatic logic [15:0] be16(
    input logic [511:0] d,
    input int           off
  );
    return {d[8*off +: 8], d[8*(off+1) +: 8]};
  endfunction

  function automatic logic [31:0] be32(
    input logic [511:0] d,
    input int           off
  );
    return {be16(d, off), be16(d, off + 2)};
  endfunction

  // HC' = ~(~HC + ~m + m') with end-around carry.
  function automatic logic [15:0] csum16_update(
    input logic [15:0] old,
    input logic [15:0] m_old,
    input logic [15:0] m_new
  );
    logic [17:0] s;
    s = {2'b00, ~old} + {2'b00, ~m_old} + {2'b00, m_new};
    s = {2'b00, s[15:0]} + {16'h0, s[17:16]};
    s = {2'b00, s[15:0]} + {16'h0, s[17:16]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/axis_reg_slice_512.sv
// One registered valid/ready stage; ready passes through when full
// so a full pipeline still moves one beat per cycle.
module axis_reg_slice_512 #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/udp_calc_engine.sv
// UDP calculator packet stage: parse/compute, then patch result.
// Optional CALC_CSUM_UPDATE_EN also patches the UDP checksum.
module udp_calc_engine
  import calc_pkg::*;
#(
  parameter int          DATA_WIDTH    = 512,
  parameter logic [15:0] CALC_UDP_PORT = 16'd4321,
  parameter logic [15:0] OPC_ADD       = OPC_ADD_DEF,
  parameter logic [15:0] OPC_SUB       = OPC_SUB_DEF
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic                  calc_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [5:0]            s_axis_tuser_mty,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [5:0]            m_axis_tuser_mty,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           stat_calc_cnt,
  output logic [31:0]           stat_bypass_cnt
);

  localparam int S1W = DATA_WIDTH + 6 + 1 + 1 + 32;
  localparam int S2W = DATA_WIDTH + 6 + 1;

  state_e      state_q, state_d;
  logic [31:0] calc_cnt_q, calc_cnt_d;
  logic [31:0] byp_cnt_q, byp_cnt_d;

  logic        s_fire;
  logic        hdr_ok, opc_add, opc_sub;
  logic        len_ok, match;
  logic [31:0] op_a, op_b, result;

  assign s_fire = s_axis_tvalid && s_axis_tready;

  always_comb begin
    hdr_ok = (be16(s_axis_tdata, OFF_TPID) == TPID_VLAN)
          && (be16(s_axis_tdata, OFF_ETYPE) == ETYPE_IPV4)
          && (byte_at(s_axis_tdata, OFF_VERIHL) == IPV4_VERIHL)
          && (byte_at(s_axis_tdata, OFF_PROTO) == PROTO_UDP)
          && (be16(s_axis_tdata, OFF_DPORT) == CALC_UDP_PORT);
    opc_add = be16(s_axis_tdata, OFF_OPC) == OPC_ADD;
    opc_sub = be16(s_axis_tdata, OFF_OPC) == OPC_SUB;
    len_ok  = !s_axis_tlast || (s_axis_tuser_mty <= MTY_MAX_SOP);
    match   = calc_en && hdr_ok && (opc_add || opc_sub)
           && len_ok && (state_q == ST_SOP);
    op_a    = be32(s_axis_tdata, OFF_A);
    op_b    = be32(s_axis_tdata, OFF_B);
    result  = opc_add ? op_a + op_b : op_a - op_b;
  end

  always_comb begin
    state_d    = state_q;
    calc_cnt_d = calc_cnt_q;
    byp_cnt_d  = byp_cnt_q;
    if (s_fire) begin
      unique case (state_q)
        ST_SOP: begin
          if (match) calc_cnt_d = calc_cnt_q + 32'd1;
          else       byp_cnt_d  = byp_cnt_q + 32'd1;
          state_d = s_axis_tlast ? ST_SOP : ST_BODY;
        end
        ST_BODY: begin
          if (s_axis_tlast) state_d = ST_SOP;
        end
        default: state_d = ST_SOP;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q    <= ST_SOP;
      calc_cnt_q <= '0;
      byp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      calc_cnt_q <= calc_cnt_d;
      byp_cnt_q  <= byp_cnt_d;
    end
  end

  assign stat_calc_cnt   = calc_cnt_q;
  assign stat_bypass_cnt = byp_cnt_q;

  logic [S1W-1:0]        s1_in, s1_out;
  logic                  s1_valid, s1_ready;
  logic [DATA_WIDTH-1:0] s1_tdata;
  logic [5:0]            s1_mty;
  logic                  s1_last, s1_match;
  logic [31:0]           s1_result;

  assign s1_in = {result, match, s_axis_tlast,
                  s_axis_tuser_mty, s_axis_tdata};

  axis_reg_slice_512 #(.W(S1W)) u_stage1 (
    .clk       (axis_aclk),
    .rst       (axis_rst),
    .in_data   (s1_in),
    .in_valid  (s_axis_tvalid),
    .in_ready  (s_axis_tready),
    .out_data  (s1_out),
    .out_valid (s1_valid),
    .out_ready (s1_ready)
  );

  assign {s1_result, s1_match, s1_last,
          s1_mty, s1_tdata} = s1_out;

  logic [DATA_WIDTH-1:0] p_data;

`ifdef CALC_CSUM_UPDATE_EN
  logic [15:0] cs_old, cs_mid, cs_new, cs_out;

  always_comb begin
    cs_old = be16(s1_tdata, OFF_CSUM);
    cs_mid = csum16_update(cs_old, be16(s1_tdata, OFF_RES),
                           s1_result[31:16]);
    cs_new = csum16_update(cs_mid, be16(s1_tdata, OFF_RES + 2),
                           s1_result[15:0]);
    // Zero means "no checksum" in UDP and must be preserved.
    if (cs_old == 16'h0000)      cs_out = 16'h0000;
    else if (cs_new == 16'h0000) cs_out = 16'hFFFF;
    else                         cs_out = cs_new;
  end
`endif

  always_comb begin
    p_data = s1_tdata;
    if (s1_match) begin
      p_data[8*OFF_RES +: 8]     = s1_result[31:24];
      p_data[8*(OFF_RES+1) +: 8] = s1_result[23:16];
      p_data[8*(OFF_RES+2) +: 8] = s1_result[15:8];
      p_data[8*(OFF_RES+3) +: 8] = s1_result[7:0];
`ifdef CALC_CSUM_UPDATE_EN
      p_data[8*OFF_CSUM +: 8]     = cs_out[15:8];
      p_data[8*(OFF_CSUM+1) +: 8] = cs_out[7:0];
`endif
    end
  end

  logic [S2W-1:0] s2_in, s2_out;

  assign s2_in = {s1_last, s1_mty, p_data};

  axis_reg_slice_512 #(.W(S2W)) u_stage2 (
    .clk       (axis_aclk),
    .rst       (axis_rst),
    .in_data   (s2_in),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .out_data  (s2_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata} = s2_out;

endmodule

// File: tb/tb_udp_calc_engine.sv
// Scoreboard bench for udp_calc_engine.
// Build with +define+CALC_CSUM_UPDATE_EN to check checksum patching.
module tb_udp_calc_engine;

  logic         clk = 1'b0;
  logic         axis_rst = 1'b1;
  logic         calc_en = 1'b1;
  logic [511:0] s_tdata = '0;
  logic [5:0]   s_mty = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [511:0] m_tdata;
  logic [5:0]   m_mty;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
  logic [31:0]  stat_calc, stat_byp;

  udp_calc_engine dut (
    .axis_aclk        (clk),
    .axis_rst         (axis_rst),
    .calc_en          (calc_en),
    .s_axis_tdata     (s_tdata),
    .s_axis_tuser_mty (s_mty),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tlast     (s_tlast),
    .m_axis_tdata     (m_tdata),
    .m_axis_tuser_mty (m_mty),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tlast     (m_tlast),
    .stat_calc_cnt    (stat_calc),
    .stat_bypass_cnt  (stat_byp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic [5:0]   mty;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  bit          gaps = 0;
  logic [31:0] exp_calc = 0;
  logic [31:0] exp_byp = 0;

  task automatic check_eq(input string tag,
                          input logic [511:0] got,
                          input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] mk_req(
    input logic [15:0] port, input logic [15:0] opc,
    input logic [31:0] a, input logic [31:0] b,
    input logic [15:0] cs);
    logic [511:0] d;
    d = rnd512();
    d[8*12 +: 8] = 8'h81; d[8*13 +: 8] = 8'h00;
    d[8*16 +: 8] = 8'h08; d[8*17 +: 8] = 8'h00;
    d[8*18 +: 8] = 8'h45; d[8*27 +: 8] = 8'h11;
    d[8*40 +: 8] = port[15:8]; d[8*41 +: 8] = port[7:0];
    d[8*44 +: 8] = cs[15:8];   d[8*45 +: 8] = cs[7:0];
    d[8*46 +: 8] = opc[15:8];  d[8*47 +: 8] = opc[7:0];
    for (int i = 0; i < 4; i++) begin
      d[8*(48+i) +: 8] = a[8*(3-i) +: 8];
      d[8*(52+i) +: 8] = b[8*(3-i) +: 8];
      d[8*(56+i) +: 8] = 8'h00;
    end
    return d;
  endfunction

  function automatic logic [15:0] g16(input logic [511:0] d,
                                      input int o);
    return {d[8*o +: 8], d[8*(o+1) +: 8]};
  endfunction

  function automatic logic [511:0] model(
    input logic [511:0] d, input logic last,
    input logic [5:0] mty, input logic en, output logic hit);
    logic [511:0] e;
    logic [31:0]  a, b, r, s;
    logic [15:0]  opc, cs;
    e = d;
    opc = g16(d, 46);
    a = {g16(d, 48), g16(d, 50)};
    b = {g16(d, 52), g16(d, 54)};
    hit = en && g16(d, 12) == 16'h8100 && g16(d, 16) == 16'h0800
       && d[8*18 +: 8] == 8'h45 && d[8*27 +: 8] == 8'h11
       && g16(d, 40) == 16'd4321
       && (opc == 16'h000D || opc == 16'h001A)
       && (!last || mty <= 6'd4);
    if (hit) begin
      r = (opc == 16'h000D) ? a + b : a - b;
      for (int i = 0; i < 4; i++) e[8*(56+i) +: 8] = r[8*(3-i) +: 8];
`ifdef CALC_CSUM_UPDATE_EN
      cs = g16(d, 44);
      if (cs != 16'h0) begin
        s = {16'h0, ~cs} + {16'h0, ~g16(d, 56)} + {16'h0, r[31:16]}
          + {16'h0, ~g16(d, 58)} + {16'h0, r[15:0]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        cs = ~s[15:0];
        if (cs == 16'h0) cs = 16'hFFFF;
      end
      e[8*44 +: 8] = cs[15:8];
      e[8*45 +: 8] = cs[7:0];
`else
      cs = 16'h0;
      s = {16'h0, cs};
`endif
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    beat_t        e;
    bit           prev_stall = 0;
    logic [518:0] prev_out = '0;
    forever begin
      @(negedge clk);
      if (axis_rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check_eq("hold", {m_tvalid, m_tlast, m_mty, m_tdata},
                   {1'b1, prev_out});
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("data", m_tdata, e.d);
            check_eq("mty", m_mty, e.mty);
            check_eq("last", m_tlast, e.last);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out = {m_tlast, m_mty, m_tdata};
      end
    end
  end

  task automatic drive_beat(input logic [511:0] d,
                            input logic [5:0] mty,
                            input logic last,
                            output bit ok);
    int n;
    ok = 0;
    if (gaps) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    s_tdata = d; s_mty = mty; s_tlast = last; s_tvalid = 1'b1;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
      n++;
    end
    s_tvalid = 1'b0;
    if (!ok) check_eq("tready_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [511:0] d0,
                            input int nb,
                            input logic [5:0] last_mty,
                            input logic en);
    logic [511:0] d, e;
    logic [5:0]   mty;
    logic         last, hit;
    bit           ok;
    beat_t        b;
    calc_en = en;
    for (int i = 0; i < nb; i++) begin
      d = (i == 0) ? d0 : rnd512();
      last = (i == nb - 1);
      mty = last ? last_mty : 6'd0;
      e = d;
      hit = 0;
      if (i == 0) e = model(d, last, mty, en, hit);
      drive_beat(d, mty, last, ok);
      if (ok) begin
        b.d = e; b.mty = mty; b.last = last;
        exp_q.push_back(b);
        if (i == 0) begin
          if (hit) exp_calc++;
          else     exp_byp++;
        end
      end
      if (i == 0) calc_en = ~en;
    end
    calc_en = en;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_calc"}, stat_calc, exp_calc);
    check_eq({tag, "_byp"}, stat_byp, exp_byp);
  endtask

  initial begin
    logic [511:0] d;
    logic [15:0]  opc;
    bit           ok;
    repeat (3) @(posedge clk);
    #1;
    axis_rst = 1'b0;
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tlast", m_tlast, 0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_mty", m_mty, 0);
    check_eq("rst_tready", s_tready, 1);
    check_stats("rst");

    // First SUB frame also measures pipeline latency.
    d = mk_req(16'd4321, 16'h001A, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd0, 1'b1);
    check_eq("lat_edge1", m_tvalid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_edge2", m_tvalid, 1);
    check_eq("sub_res", m_tdata[8*56 +: 32], 32'h01000000);
    drain();
    check_stats("sub");

    d = mk_req(16'd4321, 16'h000D, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd0, 1'b1);
    d = mk_req(16'd4321, 16'h001A, 32'd0, 32'd1, 16'h1234);
    send_frame(d, 1, 6'd0, 1'b1);
    d = mk_req(16'd4321, 16'h000D, 32'hFFFFFFFF, 32'd2, 16'hABCD);
    send_frame(d, 1, 6'd0, 1'b1);
    d = mk_req(16'd4321, 16'h001A, 32'd9, 32'd4, 16'h0000);
    send_frame(d, 1, 6'd4, 1'b1);
    drain();
    check_stats("arith");

    d = mk_req(16'd4322, 16'h000D, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd0, 1'b1);
    drain();
    check_stats("byp_port");
    d = mk_req(16'd4321, 16'h0001, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd0, 1'b1);
    drain();
    check_stats("byp_opc");
    d = mk_req(16'd4321, 16'h000D, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd0, 1'b0);
    drain();
    check_stats("byp_en");
    d = mk_req(16'd4321, 16'h000D, 32'd3, 32'd2, 16'h594D);
    send_frame(d, 1, 6'd8, 1'b1);
    drain();
    check_stats("byp_mty");

    rdy_mode = 1;
    gaps = 1;
    d = mk_req(16'd4321, 16'h001A, 32'd100, 32'd58, 16'h7777);
    send_frame(d, 3, 6'd17, 1'b1);
    d = mk_req(16'd4322, 16'h001A, 32'd100, 32'd58, 16'h7777);
    send_frame(d, 3, 6'd33, 1'b1);
    drain();
    check_stats("multi");

    rdy_mode = 2;
    gaps = 0;
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: opc = 16'h000D;
        1: opc = 16'h001A;
        default: opc = 16'h0001;
      endcase
      d = mk_req(($urandom_range(0, 3) == 0) ? 16'd4322 : 16'd4321,
                 opc, $urandom, $urandom, 16'($urandom));
      send_frame(d, $urandom_range(1, 4), 6'($urandom_range(0, 63)),
                 ($urandom_range(0, 4) != 0));
    end
    drain();
    check_stats("rand");

    // Reset while beat 2 of a 3-beat frame is on the input.
    rdy_mode = 0;
    d = mk_req(16'd4321, 16'h000D, 32'd1, 32'd1, 16'h1111);
    calc_en = 1'b1;
    drive_beat(d, 6'd0, 1'b0, ok);
    drive_beat(rnd512(), 6'd0, 1'b0, ok);
    s_tdata = rnd512(); s_tlast = 1'b0; s_tvalid = 1'b1;
    axis_rst = 1'b1;
    @(posedge clk);
    #1;
    axis_rst = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_calc = 0;
    exp_byp = 0;
    check_eq("midrst_tvalid", m_tvalid, 0);
    check_eq("midrst_tready", s_tready, 1);
    check_stats("midrst");

    d = mk_req(16'd4321, 16'h001A, 32'd7, 32'd2, 16'h2222);
    send_frame(d, 1, 6'd0, 1'b1);
    drain();
    check_stats("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
